// File: rtl/spi_slave_rx_mode2.sv
// SPI mode-2 (CPOL=1, CPHA=0) receive-only slave, oversampled by In_clk.
// Bytes arrive MSB first; each complete byte yields a one-cycle valid pulse.
module spi_slave_rx_mode2 #(
    parameter int unsigned REF_CLK  = 50_000_000,
    parameter int unsigned SPI_SCLK = 500_000
) (
    input  logic       In_clk,
    input  logic       In_rst_n,
    input  logic       In_spi_cs_n,
    input  logic       In_spi_sclk,
    input  logic       In_spi_mosi,
    output logic [7:0] Out_rx_data,
    output logic       Out_rx_valid,
    output logic       Out_rx_err,
    output logic       Out_rx_busy
);

    if (REF_CLK < 8 * SPI_SCLK) begin : g_clk_ratio_check
        $error("spi_slave_rx_mode2: REF_CLK must be at least 8 * SPI_SCLK");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    logic   cs_s1_q, cs_s2_q, cs_h_q;
    logic   sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic   mosi_s1_q, mosi_s2_q, mosi_h_q;
    state_t state_q;
    logic [2:0] cnt_q;
    logic [7:0] shift_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       rx_err_q;

    logic       sclk_fall;
    logic       cs_rise;
    logic [7:0] shift_d;

    // All three lines share the same depth so MOSI stays aligned with SCLK/CS.
    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_h_q    <= 1'b1;
            sclk_s1_q <= 1'b1;
            sclk_s2_q <= 1'b1;
            sclk_h_q  <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            mosi_h_q  <= 1'b0;
        end else begin
            cs_s1_q   <= In_spi_cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_h_q    <= cs_s2_q;
            sclk_s1_q <= In_spi_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
            mosi_s1_q <= In_spi_mosi;
            mosi_s2_q <= mosi_s1_q;
            mosi_h_q  <= mosi_s2_q;
        end
    end

    always_comb begin
        sclk_fall = sclk_h_q & ~sclk_s2_q;
        cs_rise   = ~cs_h_q & cs_s2_q;
        shift_d   = {shift_q[6:0], mosi_s2_q};
    end

    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    shift_q <= '0;
                    if (!cs_s2_q) begin
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    // CS release wins over a coincident SCLK edge.
                    if (cs_rise) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        shift_q <= '0;
                        if (cnt_q != 3'd0) begin
                            rx_err_q <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_q  <= shift_d;
                            rx_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Out_rx_data  = rx_data_q;
    assign Out_rx_valid = rx_valid_q;
    assign Out_rx_err   = rx_err_q;
    assign Out_rx_busy  = (state_q == RECV);

    logic unused_hist;
    assign unused_hist = mosi_h_q;

endmodule

// File: tb/tb_spi_slave_rx_mode2.sv
// Directed bench for spi_slave_rx_mode2: 50 MHz system clock, 500 kHz SCLK,
// with a monitor that records every valid byte and error pulse.
module tb_spi_slave_rx_mode2;

    localparam int unsigned HALF_SCLK = 1000;
    localparam int unsigned CLK_PER   = 20;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       rx_busy;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned valid_cnt;
    int unsigned err_cnt;
    int unsigned both_cnt;
    logic [7:0]  rxq[$];
    time         t_fall;
    time         t_valid;

    spi_slave_rx_mode2 #(
        .REF_CLK (50_000_000),
        .SPI_SCLK(500_000)
    ) dut (
        .In_clk      (clk),
        .In_rst_n    (rst_n),
        .In_spi_cs_n (cs_n),
        .In_spi_sclk (sclk),
        .In_spi_mosi (mosi),
        .Out_rx_data (rx_data),
        .Out_rx_valid(rx_valid),
        .Out_rx_err  (rx_err),
        .Out_rx_busy (rx_busy)
    );

    initial clk = 1'b0;
    always #(CLK_PER / 2) clk = ~clk;

    // Every high cycle is counted, so a stretched pulse shows up as an extra byte.
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt = valid_cnt + 1;
            rxq.push_back(rx_data);
            t_valid = $time;
        end
        if (rx_err) err_cnt = err_cnt + 1;
        if (rx_valid && rx_err) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        if (rxq.size() == 0) v = 'x;
        else v = rxq.pop_front();
        chk(tag, {24'd0, v}, {24'd0, exp});
    endtask

    task automatic send_bits(input logic [7:0] b, input int unsigned nbits);
        for (int unsigned i = 0; i < nbits; i++) begin
            mosi = b[7 - i];
            #(HALF_SCLK);
            sclk = 1'b0;
            t_fall = $time;
            #(HALF_SCLK);
            sclk = 1'b1;
        end
    endtask

    task automatic frame(input logic [7:0] b);
        cs_n = 1'b0;
        #(HALF_SCLK);
        send_bits(b, 8);
        #(HALF_SCLK);
        cs_n = 1'b1;
        #(HALF_SCLK);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        valid_cnt = 0; err_cnt = 0; both_cnt = 0;
        t_fall = 0; t_valid = 0;
        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b1; mosi = 1'b0;

        // Offset stimulus from clock edges; all later delays keep this phase.
        #53;
        chk("rst_data", {24'd0, rx_data}, 32'h00);
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_err", {31'd0, rx_err}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        #(HALF_SCLK);

        // Single 0xA5 frame, busy while selected, latency bound.
        cs_n = 1'b0;
        #(HALF_SCLK);
        chk("busy_in_frame", {31'd0, rx_busy}, 32'd1);
        send_bits(8'hA5, 8);
        #(HALF_SCLK);
        cs_n = 1'b1;
        #(HALF_SCLK);
        chk("a5_count", valid_cnt, 32'd1);
        pop_chk("a5_data", 8'hA5);
        chk("a5_port", {24'd0, rx_data}, 32'hA5);
        chk("a5_latency", {31'd0, (t_valid > t_fall) && (t_valid - t_fall <= 4 * CLK_PER)}, 32'd1);
        chk("a5_no_err", err_cnt, 32'd0);

        // 5 bits of 0xC3 then CS release: error, no byte, data held.
        cs_n = 1'b0;
        #(HALF_SCLK);
        send_bits(8'hC3, 5);
        #(HALF_SCLK);
        cs_n = 1'b1;
        #(HALF_SCLK);
        chk("part_err", err_cnt, 32'd1);
        chk("part_no_valid", valid_cnt, 32'd1);
        chk("part_hold", {24'd0, rx_data}, 32'hA5);
        chk("part_busy", {31'd0, rx_busy}, 32'd0);
        frame(8'h3C);
        chk("3c_count", valid_cnt, 32'd2);
        pop_chk("3c_data", 8'h3C);
        chk("3c_err", err_cnt, 32'd1);

        // Back-to-back frames with CS high between them.
        frame(8'h00);
        chk("b2b_busy0", {31'd0, rx_busy}, 32'd0);
        frame(8'h01);
        chk("b2b_busy1", {31'd0, rx_busy}, 32'd0);
        frame(8'h02);
        chk("b2b_busy2", {31'd0, rx_busy}, 32'd0);
        frame(8'hFF);
        chk("b2b_count", valid_cnt, 32'd6);
        pop_chk("b2b_d0", 8'h00);
        pop_chk("b2b_d1", 8'h01);
        pop_chk("b2b_d2", 8'h02);
        pop_chk("b2b_d3", 8'hFF);
        chk("b2b_port", {24'd0, rx_data}, 32'hFF);

        // Two bytes within a single CS-low window.
        cs_n = 1'b0;
        #(HALF_SCLK);
        send_bits(8'h12, 8);
        send_bits(8'h34, 8);
        #(HALF_SCLK);
        cs_n = 1'b1;
        #(HALF_SCLK);
        chk("two_count", valid_cnt, 32'd8);
        pop_chk("two_d0", 8'h12);
        pop_chk("two_d1", 8'h34);
        chk("two_err", err_cnt, 32'd1);

        // SCLK activity while deselected must be ignored.
        send_bits(8'h96, 8);
        chk("desel_busy", {31'd0, rx_busy}, 32'd0);
        #(HALF_SCLK);
        chk("desel_valid", valid_cnt, 32'd8);
        chk("desel_err", err_cnt, 32'd1);
        chk("desel_port", {24'd0, rx_data}, 32'h34);

        // Reset after 4 bits: outputs cleared, no error, next frame clean.
        cs_n = 1'b0;
        #(HALF_SCLK);
        send_bits(8'hF0, 4);
        rst_n = 1'b0;
        #(2 * CLK_PER);
        cs_n = 1'b1;
        chk("mrst_data", {24'd0, rx_data}, 32'h00);
        chk("mrst_busy", {31'd0, rx_busy}, 32'd0);
        chk("mrst_valid", {31'd0, rx_valid}, 32'd0);
        #(HALF_SCLK);
        rst_n = 1'b1;
        #(HALF_SCLK);
        chk("mrst_no_err", err_cnt, 32'd1);
        frame(8'h5A);
        chk("5a_count", valid_cnt, 32'd9);
        pop_chk("5a_data", 8'h5A);
        chk("5a_err", err_cnt, 32'd1);
        chk("never_both", both_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx_mode2.md
SPI_SLAVE_RX_MODE2 -- requirements
Module: spi_slave_rx_mode2

Interface
REQ-001 SHALL have parameter REF_CLK, default 50_000_000, In_clk frequency in Hz.
REQ-002 SHALL have parameter SPI_SCLK, default 500_000, maximum In_spi_sclk frequency in Hz; elaboration SHALL fail if REF_CLK < 8*SPI_SCLK.
REQ-003 SHALL have port In_clk, input, 1, system clock.
REQ-004 SHALL have port In_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port In_spi_cs_n, input, 1, chip select, active low, asynchronous to In_clk.
REQ-006 SHALL have port In_spi_sclk, input, 1, SPI clock, idle high (CPOL=1), asynchronous to In_clk.
REQ-007 SHALL have port In_spi_mosi, input, 1, serial data, MSB first, asynchronous to In_clk.
REQ-008 SHALL have port Out_rx_data, output, 8, last complete received byte.
REQ-009 SHALL have port Out_rx_valid, output, 1, one-cycle pulse marking a new Out_rx_data.
REQ-010 SHALL have port Out_rx_err, output, 1, one-cycle pulse on an aborted partial byte.
REQ-011 SHALL have port Out_rx_busy, output, 1, high while a frame is selected (state RECV).

Function
REQ-012 SHALL pass In_spi_cs_n, In_spi_sclk and In_spi_mosi through identical 2-flop synchronizers plus one history register each, so the three signals stay aligned.
REQ-013 SHALL detect the SCLK falling edge as synchronized history=1 and current=0, and the CS rising edge as synchronized history=0 and current=1.
REQ-014 SHALL sample MOSI on the synchronized SCLK falling edge only (mode 2: CPOL=1, CPHA=0); SCLK rising edges SHALL be ignored.
REQ-015 SHALL implement an FSM with states IDLE and RECV.
REQ-016 IDLE -> RECV SHALL occur when synchronized CS is low; in IDLE, bit counter = 0 and SCLK edges are ignored.
REQ-017 In RECV, each sampled bit SHALL shift into an 8-bit shift register LSB end (shift left) and the 3-bit counter SHALL increment, wrapping 7 -> 0.
REQ-018 On the 8th sample (counter 7 -> 0), the cycle after detection SHALL load Out_rx_data with the full byte and pulse Out_rx_valid for exactly one In_clk cycle.
REQ-019 Out_rx_data SHALL hold its value until the next valid byte, including across errors.
REQ-020 Multiple bytes within one CS-low window SHALL each produce their own valid pulse, with no gap requirement beyond normal SCLK timing.
REQ-021 RECV -> IDLE SHALL occur on the synchronized CS rising edge.
REQ-022 If the counter is 1..7 at that point, SHALL pulse Out_rx_err for one cycle, discard the partial byte, and clear the counter.
REQ-023 If the counter is 0 at the CS rising edge, no error SHALL be raised.
REQ-024 A SCLK falling edge in the same cycle as a CS rising edge SHALL be ignored; CS takes priority.
REQ-025 Out_rx_valid and Out_rx_err SHALL never be high in the same cycle.
REQ-026 Total latency from the 8th physical SCLK falling edge to Out_rx_valid SHALL be 4 In_clk cycles at most (3 synchronizer/edge cycles plus 1 output register).

Reset
REQ-027 While In_rst_n=0, SHALL immediately force: Out_rx_data=8'h00, Out_rx_valid=0, Out_rx_err=0, Out_rx_busy=0, FSM=IDLE, counter=0, shift register=0, and all synchronizer flops for CS/SCLK=1 (idle) and for MOSI=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte without an error pulse.
REQ-029 After reset release, reception SHALL begin only from a CS low level seen through the synchronizer.

Verification
REQ-030 Frame 0xA5 at SCLK=500 kHz, REF_CLK=50 MHz -> one Out_rx_valid pulse, Out_rx_data=8'hA5, Out_rx_err never high.
REQ-031 Back-to-back CS frames 0x00, 0x01, 0x02, 0xFF -> four valid pulses with data in order, Out_rx_busy low between frames.
REQ-032 One CS-low window carrying 0x12 then 0x34 -> two valid pulses, data 8'h12 then 8'h34, no error.
REQ-033 CS raised after 5 bits of 0xC3, then full frame 0x3C -> one Out_rx_err pulse, no valid for the partial byte, Out_rx_data stays 8'hA5 (prior byte), then valid with 8'h3C.
REQ-034 SCLK toggling with CS held high -> no valid, no err, Out_rx_busy=0.
REQ-035 Reset pulse after 4 bits of a frame -> all outputs at reset values, no err; next full frame 0x5A received correctly.
